// File: rtl/debounce.sv
// Pushbutton conditioner: two-flop synchroniser followed by a stability-count
// debouncer producing a clean level plus one-cycle rise/fall strobes.
module debounce #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic p1,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             p1_d;
    logic             rise_d;
    logic             fall_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            state_q <= LOW;
            cnt_q   <= '0;
            p1      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1      <= p1_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW: begin
                if (sync2) begin
                    state_d = RISE_WAIT;
                    cnt_d   = '0;
                end
            end
            RISE_WAIT: begin
                if (!sync2) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_d = FALL_WAIT;
                    cnt_d   = '0;
                end
            end
            FALL_WAIT: begin
                if (sync2) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        // Debounced level is high whenever the accepted state is the high side.
        p1_d = (state_d == HIGH) || (state_d == FALL_WAIT);
    end

endmodule
